// File: rtl/ps2_kbd_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_if -- signal bundle for the PS/2 keyboard receiver.
//
//   ps2_clk          raw PS/2 clock line (idle high, asynchronous)
//   ps2_dat          raw PS/2 data line  (idle high, asynchronous)
//   scan_code        last correctly received byte
//   scan_code_ready  one-clk pulse: scan_code just updated
//   scan_code_error  one-clk pulse: frame failed parity/stop/timeout
//
// master: the side driving the PS/2 lines (keyboard / bench)
// slave : the receiver
// ---------------------------------------------------------------------------
interface ps2_kbd_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;

  modport master (
    output ps2_clk,
    output ps2_dat,
    input  scan_code,
    input  scan_code_ready,
    input  scan_code_error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_dat,
    output scan_code,
    output scan_code_ready,
    output scan_code_error
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx -- receive-only PS/2 keyboard frame decoder.
//
// Ports:
//   clk     system clock, the only clock in the block
//   nreset  asynchronous active-low reset
//   bus     ps2_kbd_rx_if.slave: raw ps2_clk/ps2_dat in, scan_code,
//           scan_code_ready and scan_code_error out
//
// Both PS/2 lines are double-flopped, the clock is debounced by a
// FILTER_LEN-sample level filter, and each filtered falling edge samples
// the data line. Frames are start(0), 8 data LSB first, odd parity,
// stop(1). A frame that stalls for TIMEOUT cycles is dropped with an
// error pulse. Result pulses come one clk after the deciding edge cycle.
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 4000
) (
  input  logic          clk,
  input  logic          nreset,
  ps2_kbd_rx_if.slave   bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // -------------------------------------------------------------------------
  // Synchronizers (reset to the idle-high line level)
  // -------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Clock filter: the filtered level follows the synchronized clock only
  // after FILTER_LEN consecutive samples disagree with it. Any sample that
  // agrees restarts the run, so short glitches never get through.
  // -------------------------------------------------------------------------
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall_w;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Edge is flagged in the cycle the filter commits to 0, so the data
  // sample below is taken from the same cycle.
  assign fall_w = filt_q & ~filt_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM, timeout and result registers
  // -------------------------------------------------------------------------
  logic [1:0]     state_q, state_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     code_q, code_d;
  logic           rdy_q, rdy_d;
  logic           err_q, err_d;
  logic           tmo_hit_w;

  assign tmo_hit_w = (state_q != IDLE) && (tmo_q == TCW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    code_d  = code_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;

    // Saturates at TIMEOUT; the abort below returns to IDLE which clears it.
    if (state_q == IDLE || fall_w) begin
      tmo_d = '0;
    end else if (tmo_q == TCW'(TIMEOUT)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall_w) begin
      case (state_q)
        IDLE: begin
          // A 1 here is line noise or a resync point, not an error.
          if (!dat_s2_q) begin
            state_d = DATA;
            bcnt_d  = '0;
            shift_d = '0;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          bcnt_d  = '0;
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            code_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit_w) begin
      // Stalled frame: drop partial data and report once.
      state_d = IDLE;
      bcnt_d  = '0;
      shift_d = '0;
      par_d   = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      code_q  <= 8'h00;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign bus.scan_code       = code_q;
  assign bus.scan_code_ready = rdy_q;
  assign bus.scan_code_error = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx -- directed + randomized frames against a frame-level model.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;
  localparam int FL   = 8;
  localparam int TO   = 4000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  ps2_kbd_rx_if bus();
  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor state
  int   rdy_cnt = 0, err_cnt = 0, rdy_cyc = 0, err_cyc = 0, last_fall = 0;
  logic prev_pulse = 1'b0;

  // Model state: last byte accepted as a good frame
  logic [7:0] exp_code = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.scan_code_ready || bus.scan_code_error) begin
      chk("ready_error_exclusive", 32'(bus.scan_code_ready & bus.scan_code_error), 0);
      chk("pulse_not_consecutive", 32'(prev_pulse), 0);
    end
    if (bus.scan_code_ready) begin rdy_cnt++; rdy_cyc = cyc; end
    if (bus.scan_code_error) begin err_cnt++; err_cyc = cyc; end
    prev_pulse = bus.scan_code_ready | bus.scan_code_error;
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edge_bit(input logic b);
    bus.ps2_dat = b;
    wcyc(HALF / 2);
    bus.ps2_clk = 1'b0;
    last_fall = cyc;
    wcyc(HALF);
    bus.ps2_clk = 1'b1;
    wcyc(HALF / 2);
  endtask

  // Drives the first nedges bits of a frame: start, data LSB first, parity, stop.
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nedges);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nedges; i++) edge_bit(bits[i]);
    bus.ps2_dat = 1'b1;
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic frame_chk(input logic [7:0] d, input logic par, input logic stp);
    int  r0, e0, lat;
    logic good;
    r0 = rdy_cnt; e0 = err_cnt;
    send(d, par, stp, 11);
    wcyc(FL + 10);
    good = (par == odd_par(d)) && stp;
    if (good) exp_code = d;
    chk("ready_count", 32'(rdy_cnt - r0), 32'(good));
    chk("error_count", 32'(err_cnt - e0), 32'(!good));
    chk("scan_code", 32'(bus.scan_code), 32'(exp_code));
    lat = good ? rdy_cyc - last_fall : err_cyc - last_fall;
    chk("pulse_latency_in_window", 32'(lat >= FL + 1 && lat <= FL + 3), 1);
  endtask

  initial begin
    int r0, e0, lat, waited;
    logic [7:0] d;
    logic [7:0] burst [4];
    int kind;

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    nreset = 1'b0;
    wcyc(4);
    chk("reset_scan_code", 32'(bus.scan_code), 0);
    chk("reset_ready", 32'(bus.scan_code_ready), 0);
    chk("reset_error", 32'(bus.scan_code_error), 0);
    nreset = 1'b1;
    wcyc(30);
    chk("release_no_pulse", 32'(rdy_cnt + err_cnt), 0);

    // Bad parity first, so scan_code must stay at its reset value
    frame_chk(8'h1C, 1'b1, 1'b1);
    frame_chk(8'h1C, 1'b0, 1'b1);
    // Stop bit 0, then a good F0
    frame_chk(8'h33, odd_par(8'h33), 1'b0);
    frame_chk(8'hF0, odd_par(8'hF0), 1'b1);

    // Short low glitch on an idle line
    r0 = rdy_cnt; e0 = err_cnt;
    bus.ps2_clk = 1'b0;
    wcyc(3);
    bus.ps2_clk = 1'b1;
    wcyc(40);
    chk("glitch_no_pulse", 32'((rdy_cnt - r0) + (err_cnt - e0)), 0);
    frame_chk(8'h29, odd_par(8'h29), 1'b1);

    // Stalled frame: start + 5 data bits, then silence
    r0 = rdy_cnt; e0 = err_cnt;
    send(8'hA5, 1'b0, 1'b1, 6);
    waited = 0;
    while (err_cnt == e0 && waited < TO + 300) begin wcyc(1); waited++; end
    wcyc(5);
    chk("timeout_error_count", 32'(err_cnt - e0), 1);
    chk("timeout_no_ready", 32'(rdy_cnt - r0), 0);
    lat = err_cyc - last_fall;
    chk("timeout_latency_in_window", 32'(lat >= TO + FL + 1 && lat <= TO + FL + 5), 1);
    chk("timeout_scan_code", 32'(bus.scan_code), 32'(exp_code));
    frame_chk(8'h5A, odd_par(8'h5A), 1'b1);

    // Reset after start + 4 data bits
    r0 = rdy_cnt; e0 = err_cnt;
    send(8'h76, odd_par(8'h76), 1'b1, 5);
    nreset = 1'b0;
    exp_code = 8'h00;
    wcyc(3);
    chk("midreset_scan_code", 32'(bus.scan_code), 0);
    chk("midreset_ready", 32'(bus.scan_code_ready), 0);
    chk("midreset_error", 32'(bus.scan_code_error), 0);
    nreset = 1'b1;
    wcyc(30);
    chk("midreset_no_pulse", 32'((rdy_cnt - r0) + (err_cnt - e0)), 0);
    frame_chk(8'h76, odd_par(8'h76), 1'b1);

    // Random frames: good, bad parity, or bad stop
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 3);
      frame_chk(d, odd_par(d) ^ (kind == 1), kind != 2);
    end

    // Back-to-back good frames including the prefix bytes
    burst[0] = 8'hE0; burst[1] = 8'hF0; burst[2] = 8'($urandom); burst[3] = 8'($urandom);
    r0 = rdy_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) send(burst[i], odd_par(burst[i]), 1'b1, 11);
    wcyc(FL + 10);
    exp_code = burst[3];
    chk("burst_ready_count", 32'(rdy_cnt - r0), 4);
    chk("burst_error_count", 32'(err_cnt - e0), 0);
    chk("burst_scan_code", 32'(bus.scan_code), 32'(exp_code));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
